// File: rtl/pc_exception_ctrl.sv
// Fetch PC register and interrupt sequencer downstream of the PC-source mux.
// Latency: pc/epc update on the edge after selection; interrupt entry is NORMAL -> TAKE -> HANDLER.
// Backpressure: stall freezes pc, epc and state; it does not mask interrupt sampling while in HANDLER.
module pc_exception_ctrl #(
    parameter logic [31:0] PC_RESET   = 32'h0000_0000,
    parameter logic [31:0] INT_VECTOR = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_pc,
    input  logic [31:0] epc_in,
    input  logic        int_req,
    input  logic        eret,
    input  logic        stall,
    output logic [31:0] pc,
    output logic [31:0] epc,
    output logic        intt,
    output logic        int_ack,
    output logic        in_handler
);

    typedef enum logic [1:0] {
        S_NORMAL  = 2'b00,
        S_TAKE    = 2'b01,
        S_HANDLER = 2'b10
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_epc;
    logic        r_int_pending;
    logic        w_int_any;

    assign w_int_any = int_req | r_int_pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_NORMAL;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_NORMAL:  if (!stall && w_int_any) w_next_state = S_TAKE;
            S_TAKE:    if (!stall) w_next_state = S_HANDLER;
            S_HANDLER: if (eret && !stall) w_next_state = S_NORMAL;
            default:   w_next_state = S_NORMAL;
        endcase
    end

    // int_ack is qualified by stall so the source sees exactly one pulse, on the cycle TAKE completes.
    always_comb begin
        intt    = 1'b0;
        int_ack = 1'b0;
        if (r_state == S_TAKE) begin
            intt    = 1'b1;
            int_ack = !stall;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= PC_RESET;
            r_epc         <= '0;
            r_int_pending <= 1'b0;
        end else begin
            case (r_state)
                S_NORMAL: begin
                    if (!stall && !w_int_any) r_pc <= next_pc;
                end
                S_TAKE: begin
                    if (!stall) begin
                        r_epc         <= epc_in;
                        r_pc          <= INT_VECTOR;
                        r_int_pending <= 1'b0;
                    end
                end
                S_HANDLER: begin
                    // A request seen while masked is remembered even if eret leaves this cycle.
                    if (int_req) r_int_pending <= 1'b1;
                    if (!stall) r_pc <= eret ? r_epc : next_pc;
                end
                default: ;
            endcase
        end
    end

    assign pc         = r_pc;
    assign epc        = r_epc;
    assign in_handler = (r_state == S_HANDLER);

endmodule
